// File: rtl/execute_stage.sv
// Execute stage of the in-order RV32I pipeline: ALU, writeback select, branch/jump target
// and the stall/flush handshake. Define EX_MISALIGN_CHECK_EN to add ex_o_misaligned.
module execute_stage #(
  parameter int AWIDTH      = 5,
  parameter int DWIDTH      = 32,
  parameter int PC_WIDTH    = 32,
  parameter int FUNCT_WIDTH = 3
) (
  input  logic                   ex_clk,
  input  logic                   ex_rst,
  input  logic [13:0]            ex_i_alu,
  output logic [13:0]            ex_o_alu,
  input  logic [10:0]            ex_i_opcode,
  output logic [10:0]            ex_o_opcode,
  input  logic [AWIDTH-1:0]      ex_i_addr_rs1,
  output logic [AWIDTH-1:0]      ex_o_addr_rs1,
  input  logic [AWIDTH-1:0]      ex_i_addr_rs2,
  output logic [AWIDTH-1:0]      ex_o_addr_rs2,
  input  logic [AWIDTH-1:0]      ex_i_addr_rd,
  output logic [AWIDTH-1:0]      ex_o_addr_rd,
  input  logic [DWIDTH-1:0]      ex_i_data_rs1,
  output logic [DWIDTH-1:0]      ex_o_data_rs1,
  input  logic [DWIDTH-1:0]      ex_i_data_rs2,
  output logic [DWIDTH-1:0]      ex_o_data_rs2,
  input  logic [DWIDTH-1:0]      ex_i_imm,
  output logic [DWIDTH-1:0]      ex_o_imm,
  input  logic [FUNCT_WIDTH-1:0] ex_i_funct3,
  output logic [FUNCT_WIDTH-1:0] ex_o_funct3,
  input  logic [PC_WIDTH-1:0]    ex_i_pc,
  output logic [PC_WIDTH-1:0]    ex_o_pc,
  output logic [DWIDTH-1:0]      ex_o_alu_value,
  output logic [DWIDTH-1:0]      ex_o_data_rd,
  output logic [PC_WIDTH-1:0]    ex_next_pc,
  output logic                   ex_o_change_pc,
  output logic                   ex_o_we_reg,
  output logic                   ex_o_valid,
`ifdef EX_MISALIGN_CHECK_EN
  output logic                   ex_o_misaligned,
`endif
  input  logic                   ex_i_ce,
  output logic                   ex_o_ce,
  input  logic                   ex_i_stall,
  output logic                   ex_o_stall,
  input  logic                   ex_i_force_stall,
  input  logic                   ex_i_flush,
  output logic                   ex_o_flush,
  output logic                   ex_stall_from_alu
);

  localparam int ALU_ADD = 0, ALU_SUB = 1, ALU_SLT = 2, ALU_SLTU = 3, ALU_XOR = 4;
  localparam int ALU_OR = 5, ALU_AND = 6, ALU_SLL = 7, ALU_SRL = 8, ALU_SRA = 9;
  localparam int ALU_EQ = 10, ALU_NEQ = 11, ALU_GE = 12, ALU_GEU = 13;
  localparam int OP_RTYPE = 0, OP_LOAD = 2, OP_STORE = 3, OP_BRANCH = 4;
  localparam int OP_JAL = 5, OP_JALR = 6, OP_LUI = 7, OP_AUIPC = 8;
  localparam int OP_SYSTEM = 9, OP_FENCE = 10;

  logic                    stall_int;
  logic                    alu_ok, op_ok, dec_ok;
  logic [DWIDTH-1:0]       op_a, op_b;
  logic signed [DWIDTH-1:0] op_a_s, op_b_s;
  logic [4:0]              shamt;
  logic                    lt_s, lt_u, eq;
  logic [DWIDTH-1:0]       alu_raw, alu_res, wb_data;
  logic [PC_WIDTH-1:0]     pc_plus_imm, pc_plus_4, jalr_tgt, target;
  logic                    taken, redirect, change, we, mis;

  assign stall_int = ex_i_stall | ex_i_force_stall;
  assign alu_ok    = $onehot(ex_i_alu);
  assign op_ok     = $onehot(ex_i_opcode);
  assign dec_ok    = alu_ok & op_ok;

  assign op_a   = ex_i_data_rs1;
  assign op_b   = (ex_i_opcode[OP_RTYPE] | ex_i_opcode[OP_BRANCH]) ? ex_i_data_rs2 : ex_i_imm;
  assign op_a_s = op_a;
  assign op_b_s = op_b;
  assign shamt  = op_b[4:0];
  assign lt_s   = op_a_s < op_b_s;
  assign lt_u   = op_a < op_b;
  assign eq     = op_a == op_b;

  // One-hot op select; each term is masked by its own op bit so a legal op picks exactly one.
  always_comb begin
    alu_raw = '0;
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_ADD]}}  & (op_a + op_b));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_SUB]}}  & (op_a - op_b));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_SLT]}}  & {{(DWIDTH-1){1'b0}}, lt_s});
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_SLTU]}} & {{(DWIDTH-1){1'b0}}, lt_u});
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_XOR]}}  & (op_a ^ op_b));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_OR]}}   & (op_a | op_b));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_AND]}}  & (op_a & op_b));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_SLL]}}  & (op_a << shamt));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_SRL]}}  & (op_a >> shamt));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_SRA]}}  & DWIDTH'(op_a_s >>> shamt));
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_EQ]}}   & {{(DWIDTH-1){1'b0}}, eq});
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_NEQ]}}  & {{(DWIDTH-1){1'b0}}, ~eq});
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_GE]}}   & {{(DWIDTH-1){1'b0}}, ~lt_s});
    alu_raw = alu_raw | ({DWIDTH{ex_i_alu[ALU_GEU]}}  & {{(DWIDTH-1){1'b0}}, ~lt_u});
  end

  assign alu_res     = dec_ok ? alu_raw : '0;
  assign pc_plus_imm = ex_i_pc + PC_WIDTH'(ex_i_imm);
  assign pc_plus_4   = ex_i_pc + PC_WIDTH'(4);
  assign jalr_tgt    = PC_WIDTH'(ex_i_data_rs1 + ex_i_imm) & ~PC_WIDTH'(1);
  assign taken       = ex_i_opcode[OP_BRANCH] & (alu_res == DWIDTH'(1));

  always_comb begin
    wb_data = alu_res;
    target  = pc_plus_4;
    if (op_ok) begin
      if (ex_i_opcode[OP_LUI])                         wb_data = ex_i_imm;
      else if (ex_i_opcode[OP_AUIPC])                  wb_data = DWIDTH'(pc_plus_imm);
      else if (ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR]) wb_data = DWIDTH'(pc_plus_4);
      if (ex_i_opcode[OP_BRANCH] | ex_i_opcode[OP_JAL]) target = pc_plus_imm;
      else if (ex_i_opcode[OP_JALR])                    target = jalr_tgt;
    end
  end

  assign redirect = dec_ok & (ex_i_opcode[OP_JAL] | ex_i_opcode[OP_JALR] | taken);
  assign we       = dec_ok & ~(ex_i_opcode[OP_BRANCH] | ex_i_opcode[OP_STORE] |
                               ex_i_opcode[OP_FENCE]  | ex_i_opcode[OP_SYSTEM]);
`ifdef EX_MISALIGN_CHECK_EN
  // A misaligned target raises the flag instead of redirecting fetch.
  assign mis    = redirect & (target[1:0] != 2'b00);
`else
  assign mis    = 1'b0;
`endif
  assign change = redirect & ~mis;

  // Flush only kills the control bits; the data fields keep their last values.
  always_ff @(posedge ex_clk or negedge ex_rst) begin
    if (!ex_rst) begin
      ex_o_alu       <= '0;
      ex_o_opcode    <= '0;
      ex_o_addr_rs1  <= '0;
      ex_o_addr_rs2  <= '0;
      ex_o_addr_rd   <= '0;
      ex_o_data_rs1  <= '0;
      ex_o_data_rs2  <= '0;
      ex_o_imm       <= '0;
      ex_o_funct3    <= '0;
      ex_o_pc        <= '0;
      ex_o_alu_value <= '0;
      ex_o_data_rd   <= '0;
      ex_next_pc     <= '0;
      ex_o_change_pc <= 1'b0;
      ex_o_we_reg    <= 1'b0;
      ex_o_valid     <= 1'b0;
      ex_o_ce        <= 1'b0;
`ifdef EX_MISALIGN_CHECK_EN
      ex_o_misaligned <= 1'b0;
`endif
    end else if (!stall_int) begin
      if (ex_i_flush) begin
        ex_o_ce        <= 1'b0;
        ex_o_valid     <= 1'b0;
        ex_o_change_pc <= 1'b0;
        ex_o_we_reg    <= 1'b0;
`ifdef EX_MISALIGN_CHECK_EN
        ex_o_misaligned <= 1'b0;
`endif
      end else if (ex_i_ce) begin
        ex_o_alu       <= ex_i_alu;
        ex_o_opcode    <= ex_i_opcode;
        ex_o_addr_rs1  <= ex_i_addr_rs1;
        ex_o_addr_rs2  <= ex_i_addr_rs2;
        ex_o_addr_rd   <= ex_i_addr_rd;
        ex_o_data_rs1  <= ex_i_data_rs1;
        ex_o_data_rs2  <= ex_i_data_rs2;
        ex_o_imm       <= ex_i_imm;
        ex_o_funct3    <= ex_i_funct3;
        ex_o_pc        <= ex_i_pc;
        ex_o_alu_value <= alu_res;
        ex_o_data_rd   <= wb_data;
        ex_next_pc     <= target;
        ex_o_change_pc <= change;
        ex_o_we_reg    <= we;
        ex_o_valid     <= 1'b1;
        ex_o_ce        <= 1'b1;
`ifdef EX_MISALIGN_CHECK_EN
        ex_o_misaligned <= mis;
`endif
      end else begin
        ex_o_ce        <= 1'b0;
        ex_o_valid     <= 1'b0;
        ex_o_change_pc <= 1'b0;
`ifdef EX_MISALIGN_CHECK_EN
        ex_o_misaligned <= 1'b0;
`endif
      end
    end
  end

  assign ex_o_stall        = stall_int & ~ex_i_flush;
  assign ex_o_flush        = ex_i_flush | ex_o_change_pc;
  assign ex_stall_from_alu = ex_o_ce & ex_o_opcode[OP_LOAD];

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus randomized traffic
// scored against a behavioural model through an expectation queue.
module tb_execute_stage;

  logic        ex_clk = 1'b0;
  logic        ex_rst;
  logic [13:0] ex_i_alu, ex_o_alu;
  logic [10:0] ex_i_opcode, ex_o_opcode;
  logic [4:0]  ex_i_addr_rs1, ex_o_addr_rs1, ex_i_addr_rs2, ex_o_addr_rs2, ex_i_addr_rd, ex_o_addr_rd;
  logic [31:0] ex_i_data_rs1, ex_o_data_rs1, ex_i_data_rs2, ex_o_data_rs2, ex_i_imm, ex_o_imm;
  logic [2:0]  ex_i_funct3, ex_o_funct3;
  logic [31:0] ex_i_pc, ex_o_pc, ex_o_alu_value, ex_o_data_rd, ex_next_pc;
  logic        ex_o_change_pc, ex_o_we_reg, ex_o_valid;
  logic        ex_i_ce, ex_o_ce, ex_i_stall, ex_o_stall, ex_i_force_stall;
  logic        ex_i_flush, ex_o_flush, ex_stall_from_alu;
`ifdef EX_MISALIGN_CHECK_EN
  logic        ex_o_misaligned;
`endif

  typedef struct {
    logic [31:0] alu_value, data_rd, next_pc, pc, imm;
    logic [10:0] opcode;
    logic [4:0]  rd;
    logic        we, change, mis;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  logic held = 1'b0;

  execute_stage dut (
    .ex_clk(ex_clk), .ex_rst(ex_rst),
    .ex_i_alu(ex_i_alu), .ex_o_alu(ex_o_alu),
    .ex_i_opcode(ex_i_opcode), .ex_o_opcode(ex_o_opcode),
    .ex_i_addr_rs1(ex_i_addr_rs1), .ex_o_addr_rs1(ex_o_addr_rs1),
    .ex_i_addr_rs2(ex_i_addr_rs2), .ex_o_addr_rs2(ex_o_addr_rs2),
    .ex_i_addr_rd(ex_i_addr_rd), .ex_o_addr_rd(ex_o_addr_rd),
    .ex_i_data_rs1(ex_i_data_rs1), .ex_o_data_rs1(ex_o_data_rs1),
    .ex_i_data_rs2(ex_i_data_rs2), .ex_o_data_rs2(ex_o_data_rs2),
    .ex_i_imm(ex_i_imm), .ex_o_imm(ex_o_imm),
    .ex_i_funct3(ex_i_funct3), .ex_o_funct3(ex_o_funct3),
    .ex_i_pc(ex_i_pc), .ex_o_pc(ex_o_pc),
    .ex_o_alu_value(ex_o_alu_value), .ex_o_data_rd(ex_o_data_rd),
    .ex_next_pc(ex_next_pc), .ex_o_change_pc(ex_o_change_pc),
    .ex_o_we_reg(ex_o_we_reg), .ex_o_valid(ex_o_valid),
`ifdef EX_MISALIGN_CHECK_EN
    .ex_o_misaligned(ex_o_misaligned),
`endif
    .ex_i_ce(ex_i_ce), .ex_o_ce(ex_o_ce),
    .ex_i_stall(ex_i_stall), .ex_o_stall(ex_o_stall),
    .ex_i_force_stall(ex_i_force_stall),
    .ex_i_flush(ex_i_flush), .ex_o_flush(ex_o_flush),
    .ex_stall_from_alu(ex_stall_from_alu)
  );

  always #5 ex_clk = ~ex_clk;

  // Reference behaviour from the instruction semantics, using op/opcode indices.
  function automatic exp_t model(input logic [13:0] alu, input logic [10:0] opc,
                                 input logic [31:0] rs1, input logic [31:0] rs2,
                                 input logic [31:0] imm, input logic [31:0] pc,
                                 input logic [4:0] rd);
    exp_t e;
    int ai = -1, oi = -1;
    logic [31:0] b, r, tgt;
    logic [4:0] sh;
    logic ok, redirect;
    if ($countones(alu) == 1) for (int i = 0; i < 14; i++) if (alu[i]) ai = i;
    if ($countones(opc) == 1) for (int i = 0; i < 11; i++) if (opc[i]) oi = i;
    ok = (ai >= 0) && (oi >= 0);
    b  = (oi == 0 || oi == 4) ? rs2 : imm;
    sh = b[4:0];
    case (ai)
      0:  r = rs1 + b;
      1:  r = rs1 - b;
      2:  r = ($signed(rs1) < $signed(b)) ? 32'd1 : 32'd0;
      3:  r = (rs1 < b) ? 32'd1 : 32'd0;
      4:  r = rs1 ^ b;
      5:  r = rs1 | b;
      6:  r = rs1 & b;
      7:  r = rs1 << sh;
      8:  r = rs1 >> sh;
      9:  r = (rs1 >> sh) | (rs1[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
      10: r = (rs1 == b) ? 32'd1 : 32'd0;
      11: r = (rs1 != b) ? 32'd1 : 32'd0;
      12: r = ($signed(rs1) >= $signed(b)) ? 32'd1 : 32'd0;
      13: r = (rs1 >= b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    if (!ok) r = 32'd0;
    e.alu_value = r;
    case (oi)
      7:       e.data_rd = imm;
      8:       e.data_rd = pc + imm;
      5, 6:    e.data_rd = pc + 32'd4;
      default: e.data_rd = r;
    endcase
    tgt = (oi == 6) ? ((rs1 + imm) & 32'hFFFF_FFFE) : (pc + imm);
    redirect = ok && (oi == 5 || oi == 6 || (oi == 4 && r == 32'd1));
    e.we = ok && !(oi == 3 || oi == 4 || oi == 9 || oi == 10);
`ifdef EX_MISALIGN_CHECK_EN
    e.mis = redirect && (tgt[1:0] != 2'b00);
`else
    e.mis = 1'b0;
`endif
    e.change  = redirect && !e.mis;
    e.next_pc = tgt;
    e.pc = pc; e.imm = imm; e.opcode = opc; e.rd = rd;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [13:0] alu, input logic [10:0] opc,
                               input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] imm, input logic [31:0] pc,
                               input logic ce, input logic stall,
                               input logic force_stall, input logic flush);
    ex_i_alu = alu; ex_i_opcode = opc;
    ex_i_data_rs1 = rs1; ex_i_data_rs2 = rs2; ex_i_imm = imm; ex_i_pc = pc;
    ex_i_addr_rs1 = 5'($urandom); ex_i_addr_rs2 = 5'($urandom); ex_i_addr_rd = 5'($urandom);
    ex_i_funct3 = 3'($urandom);
    ex_i_ce = ce; ex_i_stall = stall; ex_i_force_stall = force_stall; ex_i_flush = flush;
    if (ce && !stall && !force_stall && !flush)
      sb_q.push_back(model(alu, opc, rs1, rs2, imm, pc, ex_i_addr_rd));
    @(posedge ex_clk);
    #1;
  endtask

  // Monitor: a fresh result is presented after any edge that was not stalled and left valid high.
  initial begin
    forever begin
      @(posedge ex_clk);
      held = ex_i_stall | ex_i_force_stall;
      @(negedge ex_clk);
      if (ex_rst && ex_o_valid && !held) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_valid", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          checkOutput("sb_alu_value", ex_o_alu_value, e.alu_value);
          checkOutput("sb_data_rd", ex_o_data_rd, e.data_rd);
          checkOutput("sb_we_reg", {31'd0, ex_o_we_reg}, {31'd0, e.we});
          checkOutput("sb_change_pc", {31'd0, ex_o_change_pc}, {31'd0, e.change});
          if (e.change) checkOutput("sb_next_pc", ex_next_pc, e.next_pc);
          checkOutput("sb_pc", ex_o_pc, e.pc);
          checkOutput("sb_imm", ex_o_imm, e.imm);
          checkOutput("sb_opcode", {21'd0, ex_o_opcode}, {21'd0, e.opcode});
          checkOutput("sb_rd", {27'd0, ex_o_addr_rd}, {27'd0, e.rd});
          checkOutput("sb_stall_from_alu", {31'd0, ex_stall_from_alu}, {31'd0, e.opcode[2]});
`ifdef EX_MISALIGN_CHECK_EN
          checkOutput("sb_misaligned", {31'd0, ex_o_misaligned}, {31'd0, e.mis});
`endif
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  localparam logic [13:0] A_ADD = 14'd1 << 0, A_SUB = 14'd1 << 1, A_SLL = 14'd1 << 7;
  localparam logic [13:0] A_SRA = 14'd1 << 9, A_EQ = 14'd1 << 10;
  localparam logic [10:0] O_R = 11'd1 << 0, O_LOAD = 11'd1 << 2, O_BR = 11'd1 << 4;
  localparam logic [10:0] O_JAL = 11'd1 << 5, O_JALR = 11'd1 << 6, O_LUI = 11'd1 << 7;
  localparam logic [10:0] O_AUIPC = 11'd1 << 8;

  initial begin
    logic [13:0] alu;
    logic [10:0] opc;
    logic [31:0] rs1, rs2, imm;
    ex_rst = 1'b0;
    ex_i_alu = '0; ex_i_opcode = '0; ex_i_addr_rs1 = '0; ex_i_addr_rs2 = '0; ex_i_addr_rd = '0;
    ex_i_data_rs1 = '0; ex_i_data_rs2 = '0; ex_i_imm = '0; ex_i_funct3 = '0; ex_i_pc = '0;
    ex_i_ce = 1'b0; ex_i_stall = 1'b0; ex_i_force_stall = 1'b0; ex_i_flush = 1'b0;
    repeat (2) @(posedge ex_clk);
    #1;
    checkOutput("rst_alu_value", ex_o_alu_value, 32'd0);
    checkOutput("rst_data_rd", ex_o_data_rd, 32'd0);
    checkOutput("rst_next_pc", ex_next_pc, 32'd0);
    checkOutput("rst_valid", {31'd0, ex_o_valid}, 32'd0);
    checkOutput("rst_ce", {31'd0, ex_o_ce}, 32'd0);
    checkOutput("rst_change_pc", {31'd0, ex_o_change_pc}, 32'd0);
    checkOutput("rst_we", {31'd0, ex_o_we_reg}, 32'd0);
    @(negedge ex_clk);
    ex_rst = 1'b1;

    applyStimulus(A_ADD, O_R, 32'd10, 32'd20, 32'd0, 32'h1000, 1, 0, 0, 0);
    checkOutput("add_alu", ex_o_alu_value, 32'h1E);
    checkOutput("add_rd", ex_o_data_rd, 32'h1E);
    checkOutput("add_we", {31'd0, ex_o_we_reg}, 32'd1);
    checkOutput("add_valid", {31'd0, ex_o_valid}, 32'd1);
    checkOutput("add_change", {31'd0, ex_o_change_pc}, 32'd0);
    checkOutput("add_pc", ex_o_pc, 32'h1000);
    applyStimulus(A_SUB, O_R, 32'd50, 32'd30, 32'd0, 32'h1004, 1, 0, 0, 0);
    checkOutput("sub_alu", ex_o_alu_value, 32'h14);
    applyStimulus(A_SLL, O_R, 32'd1, 32'd3, 32'd0, 32'h1008, 1, 0, 0, 0);
    checkOutput("sll_alu", ex_o_alu_value, 32'h8);
    applyStimulus(A_SRA, O_R, 32'hFFFF_FFF0, 32'd2, 32'd0, 32'h100C, 1, 0, 0, 0);
    checkOutput("sra_alu", ex_o_alu_value, 32'hFFFF_FFFC);
    applyStimulus(A_ADD, O_LUI, 32'd0, 32'd0, 32'hABCD_1000, 32'h1010, 1, 0, 0, 0);
    checkOutput("lui_rd", ex_o_data_rd, 32'hABCD_1000);
    applyStimulus(A_ADD, O_AUIPC, 32'd0, 32'd0, 32'h100, 32'h2000, 1, 0, 0, 0);
    checkOutput("auipc_rd", ex_o_data_rd, 32'h2100);
    checkOutput("auipc_change", {31'd0, ex_o_change_pc}, 32'd0);
    applyStimulus(A_ADD, O_JAL, 32'd0, 32'd0, 32'h10, 32'h3000, 1, 0, 0, 0);
    checkOutput("jal_rd", ex_o_data_rd, 32'h3004);
    checkOutput("jal_next_pc", ex_next_pc, 32'h3010);
    checkOutput("jal_change", {31'd0, ex_o_change_pc}, 32'd1);
    checkOutput("jal_flush_out", {31'd0, ex_o_flush}, 32'd1);
    checkOutput("jal_we", {31'd0, ex_o_we_reg}, 32'd1);
    applyStimulus(A_EQ, O_BR, 32'd10, 32'd10, 32'd4, 32'h4000, 1, 0, 0, 0);
    checkOutput("beq_next_pc", ex_next_pc, 32'h4004);
    checkOutput("beq_change", {31'd0, ex_o_change_pc}, 32'd1);
    checkOutput("beq_we", {31'd0, ex_o_we_reg}, 32'd0);
    applyStimulus(A_EQ, O_BR, 32'd10, 32'd11, 32'd4, 32'h4000, 1, 0, 0, 0);
    checkOutput("bne_change", {31'd0, ex_o_change_pc}, 32'd0);
    applyStimulus(A_ADD, O_LOAD, 32'h100, 32'd0, 32'h8, 32'h4008, 1, 0, 0, 0);
    checkOutput("load_hazard", {31'd0, ex_stall_from_alu}, 32'd1);
    applyStimulus(A_ADD, O_JALR, 32'h101, 32'd0, 32'd0, 32'h5000, 1, 0, 0, 0);
    checkOutput("jalr_next_pc", ex_next_pc, 32'h100);
    checkOutput("jalr_change", {31'd0, ex_o_change_pc}, 32'd1);

    applyStimulus(A_SUB, O_R, 32'd7, 32'd3, 32'd0, 32'h6000, 1, 1, 0, 0);
    checkOutput("stall_hold_alu", ex_o_alu_value, 32'h101);
    checkOutput("stall_hold_rd", ex_o_data_rd, 32'h5004);
    checkOutput("stall_hold_pc", ex_o_pc, 32'h5000);
    checkOutput("stall_out", {31'd0, ex_o_stall}, 32'd1);
    applyStimulus(A_SUB, O_R, 32'd7, 32'd3, 32'd0, 32'h6000, 1, 0, 1, 0);
    checkOutput("force_stall_hold_rd", ex_o_data_rd, 32'h5004);
    checkOutput("force_stall_out", {31'd0, ex_o_stall}, 32'd1);
    applyStimulus(A_SUB, O_R, 32'd7, 32'd3, 32'd0, 32'h6000, 1, 0, 0, 1);
    checkOutput("flush_valid", {31'd0, ex_o_valid}, 32'd0);
    checkOutput("flush_ce", {31'd0, ex_o_ce}, 32'd0);
    checkOutput("flush_change", {31'd0, ex_o_change_pc}, 32'd0);
    checkOutput("flush_we", {31'd0, ex_o_we_reg}, 32'd0);
    checkOutput("flush_stall_out", {31'd0, ex_o_stall}, 32'd0);
    checkOutput("flush_flush_out", {31'd0, ex_o_flush}, 32'd1);
    applyStimulus(A_SUB, O_R, 32'd7, 32'd3, 32'd0, 32'h6000, 1, 1, 0, 1);
    checkOutput("flush_masks_stall", {31'd0, ex_o_stall}, 32'd0);

    applyStimulus(A_ADD, O_R, 32'd5, 32'd6, 32'd0, 32'h7000, 1, 0, 0, 0);
    applyStimulus(A_SUB, O_R, 32'd9, 32'd1, 32'd0, 32'h7004, 0, 0, 0, 0);
    checkOutput("idle_valid", {31'd0, ex_o_valid}, 32'd0);
    checkOutput("idle_hold_alu", ex_o_alu_value, 32'd11);

    applyStimulus(A_ADD, O_JAL, 32'd0, 32'd0, 32'h20, 32'h8000, 1, 0, 0, 0);
    @(negedge ex_clk);
    #1 ex_rst = 1'b0;
    ex_i_ce = 1'b0;
    #1;
    checkOutput("async_rst_alu", ex_o_alu_value, 32'd0);
    checkOutput("async_rst_rd", ex_o_data_rd, 32'd0);
    checkOutput("async_rst_next_pc", ex_next_pc, 32'd0);
    checkOutput("async_rst_change", {31'd0, ex_o_change_pc}, 32'd0);
    checkOutput("async_rst_valid", {31'd0, ex_o_valid}, 32'd0);
    checkOutput("async_rst_pc", ex_o_pc, 32'd0);
    @(negedge ex_clk);
    ex_rst = 1'b1;

    for (int n = 0; n < 400; n++) begin
      alu = ($urandom_range(0, 15) == 0) ? 14'($urandom) : (14'd1 << $urandom_range(0, 13));
      opc = ($urandom_range(0, 15) == 0) ? 11'($urandom) : (11'd1 << $urandom_range(0, 10));
      if ($urandom_range(0, 3) == 0) opc = O_BR;
      rs1 = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40));
      rs2 = ($urandom_range(0, 3) == 0) ? rs1 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 40)));
      imm = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
      applyStimulus(alu, opc, rs1, rs2, imm, {$urandom_range(0, 32'h3FFF_FFFF), 2'b00},
                    $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                    $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 5);
    end

    applyStimulus(A_ADD, O_R, 32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0);
    repeat (3) @(posedge ex_clk);
    checkOutput("sb_drained", sb_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
Execute (EX) stage of the in-order RV32I pipeline. It sits between decode and memory. Each cycle it takes one decoded instruction (one-hot ALU op, one-hot opcode, operands, immediate, PC), computes the ALU result, writeback data and branch/jump target, and registers them with the pass-through fields for the memory stage. It also drives the PC-redirect, flush and stall controls back to fetch/decode.

Parameters:
AWIDTH, 5, register address width
DWIDTH, 32, data width
PC_WIDTH, 32, PC width
FUNCT_WIDTH, 3, funct3 width

Ports:
ex_clk  in  1  clock
ex_rst  in  1  reset, asynchronous, active-low
ex_i_alu / ex_o_alu  in/out  `ALU_WIDTH (14)  one-hot ALU op: ADD0 SUB1 SLT2 SLTU3 XOR4 OR5 AND6 SLL7 SRL8 SRA9 EQ10 NEQ11 GE12 GEU13
ex_i_opcode / ex_o_opcode  in/out  `OPCODE_WIDTH (11)  one-hot: RTYPE0 ITYPE1 LOAD2 STORE3 BRANCH4 JAL5 JALR6 LUI7 AUIPC8 SYSTEM9 FENCE10
ex_i_addr_rs1/rs2/rd, ex_o_addr_rs1/rs2/rd  in/out  AWIDTH  register addresses
ex_i_data_rs1/rs2, ex_o_data_rs1/rs2  in/out  DWIDTH  operand values
ex_i_imm / ex_o_imm  in/out  DWIDTH  sign-extended immediate (LUI: already upper<<12)
ex_i_funct3 / ex_o_funct3  in/out  FUNCT_WIDTH  funct3
ex_i_pc / ex_o_pc  in/out  PC_WIDTH  instruction PC
ex_o_alu_value  out  DWIDTH  registered raw ALU result
ex_o_data_rd  out  DWIDTH  registered writeback value
ex_next_pc  out  PC_WIDTH  registered redirect target
ex_o_change_pc  out  1  registered redirect request
ex_o_we_reg  out  1  registered rd write enable
ex_o_valid  out  1  registered result valid
ex_i_ce / ex_o_ce  in/out  1  stage enable in / next-stage enable
ex_i_stall / ex_o_stall  in/out  1  stall from downstream / stall to upstream
ex_i_force_stall  in  1  external forced stall
ex_i_flush / ex_o_flush  in/out  1  flush in / flush to upstream
ex_stall_from_alu  out  1  load-use hazard indicator

Behaviour:
- Reset (ex_rst=0, async) clears every registered output to 0.
- Operand B is rs2 for RTYPE/BRANCH and imm otherwise. Operand A is rs1.
- ALU ops: ADD/SUB wrap mod 2^32. Shifts use B[4:0]. SRA is arithmetic. SLT/SLTU/EQ/NEQ/GE/GEU produce 0/1.
- Writeback value: LUI → imm; AUIPC → pc+imm; JAL/JALR → pc+4; otherwise ALU result.
- Target: BRANCH → pc+imm when the ALU compare result is 1; JAL → pc+imm; JALR → (rs1+imm) with bit0 cleared.
- change_pc is 1 for JAL, JALR and taken branches.
- we_reg is 1 unless the opcode is BRANCH, STORE, FENCE or SYSTEM.
- Register update, 1-cycle latency: when ex_i_ce=1 and stall_int=0, where stall_int = ex_i_stall|ex_i_force_stall, all ex_o_* pipeline registers load. ex_o_ce and ex_o_valid are set to 1.
- When ex_i_ce=0 and stall_int=0: ex_o_ce, ex_o_valid and ex_o_change_pc are set to 0. The data registers hold.
- When stall_int=1, all registers hold.
- ex_i_flush=1 on a clock edge (and not stalled) clears ex_o_ce, ex_o_valid, ex_o_change_pc and ex_o_we_reg. Flush wins over ce.
- Combinational outputs:
  - ex_o_stall = stall_int & ~ex_i_flush
  - ex_o_flush = ex_i_flush | ex_o_change_pc
  - ex_stall_from_alu = ex_o_ce & ex_o_opcode[LOAD]
- A reset mid-operation discards the in-flight instruction.
- If ex_i_alu or ex_i_opcode is all-zero or multi-hot, the ALU result is 0, and we_reg and change_pc are 0.

Optional Feature:
EX_MISALIGN_CHECK_EN: adds output ex_o_misaligned (1 bit), registered with the other outputs. It is 1 when change_pc=1 and target[1:0]≠0. When it is 1, change_pc is suppressed. Without the macro the port is absent and there is no check.

Test Plan:
- Directed ALU cases, ce=1, one edge each:
  - ADD RTYPE, rs1=10, rs2=20, pc=0x1000 → alu_value=data_rd=0x1E, we=1, valid=1, change_pc=0, o_pc=0x1000.
  - SUB 50−30 → 0x14.
  - SLL 1<<3 → 0x8.
  - SRA 0xFFFFFFF0 by 2 → 0xFFFFFFFC.
- LUI imm=0xABCD1000 → data_rd=0xABCD1000. AUIPC pc=0x2000, imm=0x100 → data_rd=0x2100, change_pc=0.
- JAL pc=0x3000, imm=0x10 → data_rd=0x3004, next_pc=0x3010, change_pc=1, flush_out=1, we=1.
- BRANCH EQ rs1=rs2=10, imm=4, pc=0x4000 → next_pc=0x4004, change_pc=1, we=0. With rs2=11 → change_pc=0.
- Stall/flush:
  - ex_i_stall=1 → all outputs hold, ex_o_stall=1.
  - ex_i_flush=1 → valid=0, ce=0, ex_o_stall=0.
  - Async reset low mid-clock → all outputs 0 immediately.
- LOAD in flight → ex_stall_from_alu=1. JALR rs1=0x101, imm=0 → next_pc=0x100.
